// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter: one RAMHelper data port shared by icache fetch and dcache load/store (dcache priority, icache anti-starvation).
// Latency: grant/RAM strobes combinational; responses registered exactly 1 cycle after accept; full throughput.
// Backpressure: cmd_ready = grant, at most one accept per cycle; responses never stall. MEM_ARB_PERF_EN enables perf counters.
module mem_port_arbiter #(
  parameter logic [63:0] MEM_BASE     = 64'h8000_0000,
  parameter int          IDX_W        = 28,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             icache_cmd_valid,
  output logic             icache_cmd_ready,
  input  logic [63:0]      icache_cmd_payload_addr,
  output logic             icache_rsp_valid,
  output logic [31:0]      icache_rsp_payload_data,
  input  logic             dcache_cmd_valid,
  output logic             dcache_cmd_ready,
  input  logic [63:0]      dcache_cmd_payload_addr,
  input  logic             dcache_cmd_payload_wen,
  input  logic [63:0]      dcache_cmd_payload_wdata,
  input  logic [7:0]       dcache_cmd_payload_wstrb,
  output logic             dcache_rsp_valid,
  output logic [63:0]      dcache_rsp_payload_data,
  output logic             mem_en,
  output logic [IDX_W-1:0] mem_idx,
  output logic             mem_wen,
  output logic [63:0]      mem_wdata,
  output logic [63:0]      mem_wmask,
  input  logic [63:0]      mem_rdata,
  output logic             addr_err,
  output logic [31:0]      perf_igrant_cnt,
  output logic [31:0]      perf_dgrant_cnt,
  output logic [31:0]      perf_conflict_cnt
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic        w_req_i, w_req_d, w_grant_i, w_grant_d, w_grant_any;
  logic [63:0] w_addr, w_off, w_rdata, w_wmask;
  logic        w_in_range;
  logic        w_unused;

  logic [3:0]  r_starve_cnt;
  logic        r_irsp_vld, r_drsp_vld, r_addr_err;
  logic [31:0] r_irsp_dat;
  logic [63:0] r_drsp_dat;

  // Requests are masked while in reset so no grant can escape during reset.
  assign w_req_i     = reset_n & icache_cmd_valid;
  assign w_req_d     = reset_n & dcache_cmd_valid;
  assign w_grant_i   = w_req_i & (~w_req_d | (r_starve_cnt >= LP_LIMIT));
  assign w_grant_d   = w_req_d & ~w_grant_i;
  assign w_grant_any = w_grant_i | w_grant_d;

  assign icache_cmd_ready = w_grant_i;
  assign dcache_cmd_ready = w_grant_d;

  // Only the granted channel's address drives the RAM port.
  assign w_addr     = w_grant_i ? icache_cmd_payload_addr : dcache_cmd_payload_addr;
  assign w_off      = w_addr - MEM_BASE;
  assign w_in_range = (w_addr >= MEM_BASE) && (w_off[63:IDX_W+3] == '0);
  // Byte offset bits below the half-word select are never needed.
  assign w_unused   = ^w_off[1:0];

  assign mem_en    = w_grant_any & w_in_range;
  assign mem_wen   = w_grant_d & dcache_cmd_payload_wen & w_in_range;
  assign mem_idx   = w_off[IDX_W+2:3];
  assign mem_wdata = dcache_cmd_payload_wdata;
  assign mem_wmask = w_wmask;

  // Out-of-range reads return zero instead of whatever the RAM drives.
  assign w_rdata = w_in_range ? mem_rdata : 64'h0;

  // Expand byte strobes to a bit mask; icache never writes so its mask is zero.
  always_comb begin
    w_wmask = '0;
    for (int b = 0; b < 8; b++) begin
      w_wmask[8*b +: 8] = {8{w_grant_d & dcache_cmd_payload_wstrb[b]}};
    end
  end

  // Anti-starvation: count consecutive icache-losing cycles, saturating at 15.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= 4'd0;
    end else if (!icache_cmd_valid || w_grant_i) begin
      r_starve_cnt <= 4'd0;
    end else if (r_starve_cnt != 4'hF) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Response valids and the address-error pulse, one cycle after accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_irsp_vld <= 1'b0;
      r_drsp_vld <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_irsp_vld <= w_grant_i;
      r_drsp_vld <= w_grant_d & ~dcache_cmd_payload_wen;
      r_addr_err <= w_grant_any & ~w_in_range;
    end
  end

  // Response payloads capture on their channel's grant and hold otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_irsp_dat <= 32'h0;
      r_drsp_dat <= 64'h0;
    end else begin
      if (w_grant_i) r_irsp_dat <= w_off[2] ? w_rdata[63:32] : w_rdata[31:0];
      if (w_grant_d) r_drsp_dat <= w_rdata;
    end
  end

  assign icache_rsp_valid        = r_irsp_vld;
  assign icache_rsp_payload_data = r_irsp_dat;
  assign dcache_rsp_valid        = r_drsp_vld;
  assign dcache_rsp_payload_data = r_drsp_dat;
  assign addr_err                = r_addr_err;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_igrant_cnt, r_dgrant_cnt, r_conflict_cnt;

  // Saturating grant and conflict counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_igrant_cnt   <= 32'h0;
      r_dgrant_cnt   <= 32'h0;
      r_conflict_cnt <= 32'h0;
    end else begin
      if (w_grant_i && r_igrant_cnt != 32'hFFFF_FFFF) r_igrant_cnt <= r_igrant_cnt + 32'd1;
      if (w_grant_d && r_dgrant_cnt != 32'hFFFF_FFFF) r_dgrant_cnt <= r_dgrant_cnt + 32'd1;
      if (w_req_i && w_req_d && r_conflict_cnt != 32'hFFFF_FFFF)
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign perf_igrant_cnt   = r_igrant_cnt;
  assign perf_dgrant_cnt   = r_dgrant_cnt;
  assign perf_conflict_cnt = r_conflict_cnt;
`else
  assign perf_igrant_cnt   = 32'h0;
  assign perf_dgrant_cnt   = 32'h0;
  assign perf_conflict_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a small behavioural RAM.
// Inputs change 1ns after the rising edge; combinational outputs are sampled 1ns later,
// registered outputs 1ns after the edge that loads them.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        icache_cmd_valid, icache_cmd_ready, icache_rsp_valid;
  logic [63:0] icache_cmd_payload_addr;
  logic [31:0] icache_rsp_payload_data;
  logic        dcache_cmd_valid, dcache_cmd_ready, dcache_cmd_payload_wen, dcache_rsp_valid;
  logic [63:0] dcache_cmd_payload_addr, dcache_cmd_payload_wdata, dcache_rsp_payload_data;
  logic [7:0]  dcache_cmd_payload_wstrb;
  logic        mem_en, mem_wen, addr_err;
  logic [27:0] mem_idx;
  logic [63:0] mem_wdata, mem_wmask, mem_rdata;
  logic [31:0] perf_igrant_cnt, perf_dgrant_cnt, perf_conflict_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] ram [0:15] = '{0: 64'h1111_2222_3333_4444, 2: 64'h0123_4567_89AB_CDEF, default: 64'h0};

  always #5 clock = ~clock;

  // RAM model: combinational read, masked write on the clock edge.
  assign mem_rdata = ram[mem_idx[3:0]];
  always @(posedge clock) begin
    if (mem_en && mem_wen)
      ram[mem_idx[3:0]] <= (ram[mem_idx[3:0]] & ~mem_wmask) | (mem_wdata & mem_wmask);
  end

  mem_port_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .icache_cmd_valid(icache_cmd_valid), .icache_cmd_ready(icache_cmd_ready),
    .icache_cmd_payload_addr(icache_cmd_payload_addr),
    .icache_rsp_valid(icache_rsp_valid), .icache_rsp_payload_data(icache_rsp_payload_data),
    .dcache_cmd_valid(dcache_cmd_valid), .dcache_cmd_ready(dcache_cmd_ready),
    .dcache_cmd_payload_addr(dcache_cmd_payload_addr), .dcache_cmd_payload_wen(dcache_cmd_payload_wen),
    .dcache_cmd_payload_wdata(dcache_cmd_payload_wdata), .dcache_cmd_payload_wstrb(dcache_cmd_payload_wstrb),
    .dcache_rsp_valid(dcache_rsp_valid), .dcache_rsp_payload_data(dcache_rsp_payload_data),
    .mem_en(mem_en), .mem_idx(mem_idx), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .addr_err(addr_err),
    .perf_igrant_cnt(perf_igrant_cnt), .perf_dgrant_cnt(perf_dgrant_cnt),
    .perf_conflict_cnt(perf_conflict_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] exp_i, exp_d, exp_c;
    logic        ig;
`ifdef MEM_ARB_PERF_EN
    exp_i = 32'd2; exp_d = 32'd8; exp_c = 32'd10;
`else
    exp_i = 32'd0; exp_d = 32'd0; exp_c = 32'd0;
`endif
    // ---- reset state, with both requests asserted ----
    reset_n = 1'b0;
    icache_cmd_valid = 1'b1; icache_cmd_payload_addr = 64'h8000_0000;
    dcache_cmd_valid = 1'b1; dcache_cmd_payload_addr = 64'h8000_0008;
    dcache_cmd_payload_wen = 1'b0; dcache_cmd_payload_wdata = 64'h0; dcache_cmd_payload_wstrb = 8'h00;
    #2;
    chk("rst_iready", icache_cmd_ready, 1'b0);
    chk("rst_dready", dcache_cmd_ready, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_irsp_vld", icache_rsp_valid, 1'b0);
    chk("rst_drsp_vld", dcache_rsp_valid, 1'b0);
    chk("rst_addr_err", addr_err, 1'b0);
    chk("rst_irsp_dat", icache_rsp_payload_data, 32'h0);
    chk("rst_drsp_dat", dcache_rsp_payload_data, 64'h0);
    chk("rst_perf", {perf_igrant_cnt, perf_dgrant_cnt | perf_conflict_cnt}, 64'h0);
    icache_cmd_valid = 1'b0; dcache_cmd_valid = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();

    // ---- icache fetch, upper half, then back-to-back lower half ----
    icache_cmd_valid = 1'b1; icache_cmd_payload_addr = 64'h8000_0004;
    #1;
    chk("if_iready", icache_cmd_ready, 1'b1);
    chk("if_dready", dcache_cmd_ready, 1'b0);
    chk("if_mem_en", mem_en, 1'b1);
    chk("if_mem_idx", mem_idx, 28'd0);
    chk("if_mem_wen", mem_wen, 1'b0);
    chk("if_mem_wmask", mem_wmask, 64'h0);
    step();
    chk("if_rsp_vld", icache_rsp_valid, 1'b1);
    chk("if_rsp_dat", icache_rsp_payload_data, 32'h1111_2222);
    chk("if_drsp_vld", dcache_rsp_valid, 1'b0);
    icache_cmd_payload_addr = 64'h8000_0000;
    #1;
    chk("if2_iready", icache_cmd_ready, 1'b1);
    step();
    icache_cmd_valid = 1'b0;
    chk("if2_rsp_vld", icache_rsp_valid, 1'b1);
    chk("if2_rsp_dat", icache_rsp_payload_data, 32'h3333_4444);
    step();
    chk("if_idle_vld", icache_rsp_valid, 1'b0);
    chk("if_hold_dat", icache_rsp_payload_data, 32'h3333_4444);

    // ---- dcache store, low word strobes ----
    dcache_cmd_valid = 1'b1; dcache_cmd_payload_wen = 1'b1; dcache_cmd_payload_addr = 64'h8000_0010;
    dcache_cmd_payload_wstrb = 8'h0F; dcache_cmd_payload_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    #1;
    chk("st_dready", dcache_cmd_ready, 1'b1);
    chk("st_mem_en", mem_en, 1'b1);
    chk("st_mem_idx", mem_idx, 28'd2);
    chk("st_mem_wen", mem_wen, 1'b1);
    chk("st_mem_wmask", mem_wmask, 64'h0000_0000_FFFF_FFFF);
    chk("st_mem_wdata", mem_wdata, 64'hAAAA_BBBB_CCCC_DDDD);
    step();
    // ---- load back the merged word ----
    dcache_cmd_payload_wen = 1'b0;
    chk("st_no_rsp", dcache_rsp_valid, 1'b0);
    #1;
    chk("ld_mem_wen", mem_wen, 1'b0);
    step();
    dcache_cmd_valid = 1'b0;
    chk("ld_rsp_vld", dcache_rsp_valid, 1'b1);
    chk("ld_rsp_dat", dcache_rsp_payload_data, 64'h0123_4567_CCCC_DDDD);

    // ---- top of range is still mapped ----
    dcache_cmd_valid = 1'b1; dcache_cmd_payload_addr = 64'h0000_0000_FFFF_FFF8;
    #1;
    chk("top_mem_en", mem_en, 1'b1);
    chk("top_mem_idx", mem_idx, 28'hFFF_FFFF);
    dcache_cmd_valid = 1'b0;
    step();

    // ---- out-of-range load below base ----
    dcache_cmd_valid = 1'b1; dcache_cmd_payload_addr = 64'h7FFF_FFF8;
    #1;
    chk("oor_ld_dready", dcache_cmd_ready, 1'b1);
    chk("oor_ld_mem_en", mem_en, 1'b0);
    step();
    chk("oor_ld_err", addr_err, 1'b1);
    chk("oor_ld_rsp_vld", dcache_rsp_valid, 1'b1);
    chk("oor_ld_rsp_dat", dcache_rsp_payload_data, 64'h0);
    // ---- out-of-range store just above the window ----
    dcache_cmd_payload_wen = 1'b1; dcache_cmd_payload_addr = 64'h1_0000_0000; dcache_cmd_payload_wstrb = 8'hFF;
    #1;
    chk("oor_st_mem_en", mem_en, 1'b0);
    chk("oor_st_mem_wen", mem_wen, 1'b0);
    step();
    dcache_cmd_valid = 1'b0; dcache_cmd_payload_wen = 1'b0;
    chk("oor_st_err", addr_err, 1'b1);
    chk("oor_st_no_rsp", dcache_rsp_valid, 1'b0);
    step();
    chk("err_pulse_end", addr_err, 1'b0);

    // ---- reset mid-stream: icache builds starvation, OOR dcache load in flight ----
    icache_cmd_valid = 1'b1; icache_cmd_payload_addr = 64'h8000_0000;
    dcache_cmd_valid = 1'b1; dcache_cmd_payload_addr = 64'h7FFF_FFF8;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("pre_rst_dready", dcache_cmd_ready, 1'b1);
      step();
    end
    chk("pre_rst_err", addr_err, 1'b1);
    chk("pre_rst_drsp", dcache_rsp_valid, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_drsp", dcache_rsp_valid, 1'b0);
    chk("mid_rst_err", addr_err, 1'b0);
    chk("mid_rst_dready", dcache_cmd_ready, 1'b0);
    chk("mid_rst_iready", icache_cmd_ready, 1'b0);
    step();
    chk("in_rst_drsp", dcache_rsp_valid, 1'b0);
    icache_cmd_valid = 1'b0; dcache_cmd_valid = 1'b0;
    reset_n = 1'b1;
    step();
    chk("post_rst_drsp", dcache_rsp_valid, 1'b0);
    chk("post_rst_irsp", icache_rsp_valid, 1'b0);
    chk("post_rst_err", addr_err, 1'b0);

    // ---- continuous conflict: d,d,d,d,i repeating (starvation cleared by reset) ----
    icache_cmd_valid = 1'b1; icache_cmd_payload_addr = 64'h8000_0000;
    dcache_cmd_valid = 1'b1; dcache_cmd_payload_addr = 64'h8000_0008;
    for (int k = 0; k < 10; k++) begin
      ig = ((k % 5) == 4);
      #1;
      chk($sformatf("arb_iready_%0d", k), icache_cmd_ready, ig);
      chk($sformatf("arb_dready_%0d", k), dcache_cmd_ready, !ig);
      step();
      chk($sformatf("arb_irsp_%0d", k), icache_rsp_valid, ig);
      chk($sformatf("arb_drsp_%0d", k), dcache_rsp_valid, !ig);
    end
    icache_cmd_valid = 1'b0; dcache_cmd_valid = 1'b0;
    chk("perf_igrant", perf_igrant_cnt, exp_i);
    chk("perf_dgrant", perf_dgrant_cnt, exp_d);
    chk("perf_conflict", perf_conflict_cnt, exp_c);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
